adc_spi_reader: RTL and testbench
=================================

ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning clk cycles per adc_sclk half-period (legal range 2 to 255).
REQ-002 The block SHALL have parameter CONV_CYCLES, default 50, meaning clk cycles adc_cnv is held high per conversion (minimum 1).
REQ-003 The block SHALL have parameter SAMPLE_PERIOD, default 1000, meaning clk cycles between conversion starts (minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: level; high permits sampling.
REQ-007 The block SHALL have port clear_err, input, 1 bit: level; clears sample_miss.
REQ-008 The block SHALL have port adc_sdo, input, 1 bit: serial data from the ADC, MSB first.
REQ-009 The block SHALL have port adc_cnv, output, 1 bit: conversion start to the ADC.
REQ-010 The block SHALL have port adc_cs_n, output, 1 bit: ADC chip select, active low.
REQ-011 The block SHALL have port adc_sclk, output, 1 bit: serial clock; idles low.
REQ-012 The block SHALL have port adc_data, output, 16 bits: last completed sample, feeding the current-limit checker.
REQ-013 The block SHALL have port adc_data_valid, output, 1 bit: one-cycle pulse when adc_data updates.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 The block SHALL have port sample_miss, output, 1 bit: sticky overrun flag.

Function
REQ-016 Sample timer: 16-bit counter, held at 0 while enable is low, else increments each cycle; on reaching SAMPLE_PERIOD-1 it wraps to 0 and issues a one-cycle tick.
REQ-017 FSM states SHALL be IDLE, CONVERT, SHIFT and DONE.
REQ-018 IDLE -> CONVERT: on tick while enable is high.
REQ-019 CONVERT: adc_cnv=1 for exactly CONV_CYCLES cycles, adc_cs_n=1, adc_sclk=0, then -> SHIFT.
REQ-020 SHIFT: adc_cs_n=0; adc_sclk starts low and toggles every CLK_DIV cycles, giving 16 full periods (32 half-periods).
REQ-021 SHIFT capture: adc_sdo SHALL be sampled into a 16-bit shift register, MSB first, on the clk edge that drives adc_sclk from 1 to 0.
REQ-022 SHIFT exit: after the 16th capture adc_sclk=0 and the state -> DONE.
REQ-023 DONE (1 cycle): adc_cs_n=1; adc_data <= shift register; adc_data_valid=1; then -> IDLE.
REQ-024 adc_data SHALL hold its value between valid pulses.
REQ-025 adc_data_valid SHALL be exactly one cycle wide and never asserted in two consecutive cycles.
REQ-026 Latency: for a tick at cycle T, adc_cnv SHALL be high over T+1..T+CONV_CYCLES, adc_cs_n SHALL be low for 32*CLK_DIV cycles, and adc_data_valid SHALL pulse in the following cycle.
REQ-027 Overrun: a tick arriving while the state is not IDLE SHALL set sample_miss and SHALL be dropped (no queueing).
REQ-028 A tick and clear_err in the same cycle SHALL leave sample_miss set (set wins).
REQ-029 sample_miss SHALL clear only on clear_err, and SHALL stay set while clear_err is low.
REQ-030 enable deasserted mid-transaction: the current transaction SHALL complete, including its valid pulse, and no new conversion SHALL start.
REQ-031 Miss-free operation SHALL hold when SAMPLE_PERIOD >= CONV_CYCLES + 32*CLK_DIV + 2.

Reset
REQ-032 rstn low SHALL asynchronously force: state=IDLE, timer=0, shift register=0, adc_data=0, adc_data_valid=0, adc_cnv=0, adc_cs_n=1, adc_sclk=0, busy=0, sample_miss=0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the transaction with no valid pulse.
REQ-034 After rstn deasserts, the first tick SHALL occur SAMPLE_PERIOD cycles after enable is sampled high.

Verification
REQ-035 Reset test: hold rstn low with random inputs -> all outputs at REQ-032 values; release with enable=0 -> no activity.
REQ-036 Single-sample test: defaults, ADC model drives 0xA5C3 -> adc_cnv high 50 cycles; 16 adc_sclk periods of 8 cycles; adc_data=0xA5C3 with one valid pulse at T+50+128+1.
REQ-037 Extremes test: consecutive samples 0xFFFF then 0x0000 -> both captured exactly; valid pulses spaced 1000 cycles apart.
REQ-038 Overrun test: SAMPLE_PERIOD=100 with defaults -> sample_miss=1 after the second tick; clear_err pulse while idle -> sample_miss=0.
REQ-039 Enable-drop test: drop enable mid-SHIFT -> transaction completes with valid, then no adc_cnv for 3*SAMPLE_PERIOD cycles.
REQ-040 Mid-SHIFT reset test: assert rstn low mid-SHIFT -> adc_cs_n=1 immediately, no valid pulse, adc_data=0.

Source files
------------

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader
//  Description : Periodic reader for a CNV-triggered 16-bit serial ADC.
//                A free-running sample timer issues a tick every
//                SAMPLE_PERIOD cycles while enabled. Each tick starts one
//                transaction: CONVERT, then SHIFT, then DONE. CONVERT holds
//                adc_cnv high. SHIFT clocks 16 bits out of the ADC, MSB first.
//                DONE publishes the word with a one-cycle valid pulse.
//                A tick that arrives while a transaction is in flight is
//                dropped and raises the sticky sample_miss flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, rising edge
//    rstn           in   asynchronous active-low reset
//    enable         in   level, high permits sampling
//    clear_err      in   level, clears sample_miss
//    adc_sdo        in   ADC serial data, MSB first
//    adc_cnv        out  conversion start
//    adc_cs_n       out  ADC chip select, active low
//    adc_sclk       out  serial clock, idles low
//    adc_data[15:0] out  last completed sample
//    adc_data_valid out  one-cycle pulse when adc_data updates
//    busy           out  transaction in progress
//    sample_miss    out  sticky overrun flag
// ============================================================================
module adc_spi_reader #(
    parameter int CLK_DIV       = 4,
    parameter int CONV_CYCLES   = 50,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        adc_sdo,
    output logic        adc_cnv,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [15:0] adc_data,
    output logic        adc_data_valid,
    output logic        busy,
    output logic        sample_miss
);

    localparam int CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int DIV_W  = $clog2(CLK_DIV);

    localparam logic [15:0]       C_TIMER_LAST = 16'(SAMPLE_PERIOD - 1);
    localparam logic [CONV_W-1:0] C_CONV_LAST  = CONV_W'(CONV_CYCLES - 1);
    localparam logic [DIV_W-1:0]  C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]        C_HALF_LAST  = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q;
    logic [15:0]        timer_q, timer_d;
    logic               tick_q, tick_d;
    logic [CONV_W-1:0]  conv_cnt_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [4:0]         half_cnt_q;
    logic [15:0]        shift_q;
    logic [15:0]        data_q;
    logic               valid_q;
    logic               cnv_q;
    logic               cs_n_q;
    logic               sclk_q;
    logic               miss_q;

    // Sample timer. The tick is registered so that a tick seen in cycle T
    // starts CONVERT in cycle T+1, and the first tick lands SAMPLE_PERIOD
    // cycles after enable is first sampled high.
    always_comb begin
        timer_d = timer_q;
        tick_d  = 1'b0;
        if (!enable) begin
            timer_d = 16'd0;
        end else if (timer_q == C_TIMER_LAST) begin
            timer_d = 16'd0;
            tick_d  = 1'b1;
        end else begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= 16'd0;
            tick_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            tick_q  <= tick_d;
            // Overrun set takes priority over a simultaneous clear.
            if (tick_q && (state_q != ST_IDLE)) begin
                miss_q <= 1'b1;
            end else if (clear_err) begin
                miss_q <= 1'b0;
            end
        end
    end

    // Transaction FSM with registered ADC-facing outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            conv_cnt_q <= '0;
            div_cnt_q  <= '0;
            half_cnt_q <= 5'd0;
            shift_q    <= 16'd0;
            data_q     <= 16'd0;
            valid_q    <= 1'b0;
            cnv_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick_q && enable) begin
                        state_q    <= ST_CONVERT;
                        cnv_q      <= 1'b1;
                        conv_cnt_q <= '0;
                    end
                end
                ST_CONVERT: begin
                    if (conv_cnt_q == C_CONV_LAST) begin
                        state_q    <= ST_SHIFT;
                        cnv_q      <= 1'b0;
                        cs_n_q     <= 1'b0;
                        sclk_q     <= 1'b0;
                        div_cnt_q  <= '0;
                        half_cnt_q <= 5'd0;
                    end else begin
                        conv_cnt_q <= conv_cnt_q + CONV_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_q == C_DIV_LAST) begin
                        div_cnt_q  <= '0;
                        sclk_q     <= ~sclk_q;
                        half_cnt_q <= half_cnt_q + 5'd1;
                        // Capture on the edge that takes adc_sclk from 1 to 0.
                        if (sclk_q) begin
                            shift_q <= {shift_q[14:0], adc_sdo};
                        end
                        // The 32nd toggle is always a falling one, so the
                        // 16th bit is folded straight into the output word.
                        if (half_cnt_q == C_HALF_LAST) begin
                            state_q <= ST_DONE;
                            cs_n_q  <= 1'b1;
                            data_q  <= {shift_q[14:0], adc_sdo};
                            valid_q <= 1'b1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_cnv        = cnv_q;
    assign adc_cs_n       = cs_n_q;
    assign adc_sclk       = sclk_q;
    assign adc_data       = data_q;
    assign adc_data_valid = valid_q;
    assign busy           = (state_q != ST_IDLE);
    assign sample_miss    = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_spi_reader
//  Description : Directed self-checking bench for adc_spi_reader. One
//                instance uses default parameters; a second instance uses
//                SAMPLE_PERIOD=100 to provoke overruns. A small ADC model
//                shifts a programmed word out MSB first, advancing on each
//                falling adc_sclk edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable, clear_err, adc_sdo;
    logic        adc_cnv, adc_cs_n, adc_sclk, adc_data_valid, busy, sample_miss;
    logic [15:0] adc_data;

    logic        en2, clr2, sdo2;
    logic        cnv2, cs2, sclk2, valid2, busy2, miss2;
    logic [15:0] data2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_spi_reader dut (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (enable),
        .clear_err      (clear_err),
        .adc_sdo        (adc_sdo),
        .adc_cnv        (adc_cnv),
        .adc_cs_n       (adc_cs_n),
        .adc_sclk       (adc_sclk),
        .adc_data       (adc_data),
        .adc_data_valid (adc_data_valid),
        .busy           (busy),
        .sample_miss    (sample_miss)
    );

    adc_spi_reader #(.SAMPLE_PERIOD(100)) dut_ovr (
        .clk            (clk),
        .rstn           (rstn),
        .enable         (en2),
        .clear_err      (clr2),
        .adc_sdo        (sdo2),
        .adc_cnv        (cnv2),
        .adc_cs_n       (cs2),
        .adc_sclk       (sclk2),
        .adc_data       (data2),
        .adc_data_valid (valid2),
        .busy           (busy2),
        .sample_miss    (miss2)
    );

    // ADC model: bit index = number of falling sclk edges since CS fell.
    logic [15:0] mdl_word;
    int fall_cnt  = 0;
    int start_cnt = 0;
    int k;
    always @(negedge adc_sclk) fall_cnt = fall_cnt + 1;
    always @(negedge adc_cs_n) start_cnt = fall_cnt;
    always @* begin
        k       = fall_cnt - start_cnt;
        adc_sdo = (k >= 0 && k < 16) ? mdl_word[15 - k] : 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Entered at the first negedge where adc_cnv is seen high.
    task automatic txn_check(input logic [15:0] exp_word);
        int cnv_len, cs_len, hi, edges;
        logic prev;
        cnv_len = 0;
        while (adc_cnv && cnv_len < 5000) begin
            cnv_len++;
            @(negedge clk);
        end
        check_val("cnv_len", cnv_len, 50);
        cs_len = 0; hi = 0; edges = 0; prev = adc_sclk;
        while (!adc_cs_n && cs_len < 5000) begin
            cs_len++;
            if (adc_sclk) hi++;
            if (adc_sclk && !prev) edges++;
            prev = adc_sclk;
            @(negedge clk);
        end
        check_val("cs_low_len", cs_len, 128);
        check_val("sclk_high_cycles", hi, 64);
        check_val("sclk_rising_edges", edges, 16);
        check_val("valid_after_cs", adc_data_valid, 1);
        check_val("data_word", adc_data, exp_word);
        check_val("sclk_idle_done", adc_sclk, 0);
        @(negedge clk);
        check_val("valid_one_cycle", adc_data_valid, 0);
        check_val("data_hold", adc_data, exp_word);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, act, seen;
        rstn = 1'b0; enable = 1'b0; clear_err = 1'b0;
        en2 = 1'b0; clr2 = 1'b0; sdo2 = 1'b0; mdl_word = 16'h0;

        // Reset with random inputs
        repeat (10) begin
            @(negedge clk);
            enable    = 1'($urandom);
            clear_err = 1'($urandom);
            en2       = 1'($urandom);
            clr2      = 1'($urandom);
            sdo2      = 1'($urandom);
            mdl_word  = 16'($urandom);
        end
        @(negedge clk);
        check_val("rst_cnv", adc_cnv, 0);
        check_val("rst_cs_n", adc_cs_n, 1);
        check_val("rst_sclk", adc_sclk, 0);
        check_val("rst_data", adc_data, 0);
        check_val("rst_valid", adc_data_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_miss", sample_miss, 0);
        check_val("rst_miss2", miss2, 0);
        enable = 1'b0; clear_err = 1'b0; en2 = 1'b0; clr2 = 1'b0; sdo2 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        act = 0;
        repeat (1100) begin
            @(negedge clk);
            if (adc_cnv || !adc_cs_n || adc_sclk || adc_data_valid || busy || cnv2 || busy2)
                act++;
        end
        check_val("idle_no_activity", act, 0);

        // Single sample 0xA5C3
        mdl_word = 16'hA5C3;
        enable   = 1'b1;
        n = 0;
        while (!adc_cnv && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("first_tick_latency", n, 1001);
        txn_check(16'hA5C3);

        // Extremes, 1000 cycles apart
        mdl_word = 16'hFFFF;
        n = 1;
        while (!adc_data_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("spacing_ffff", n, 1000);
        check_val("data_ffff", adc_data, 16'hFFFF);
        mdl_word = 16'h0000;
        @(negedge clk);
        n = 1;
        while (!adc_data_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("spacing_0000", n, 1000);
        check_val("data_0000", adc_data, 16'h0000);
        check_val("no_miss_default", sample_miss, 0);

        // Enable dropped mid-SHIFT
        mdl_word = 16'h3C96;
        n = 0;
        while (adc_cs_n && n < 1200) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (!adc_data_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val("drop_valid_seen", adc_data_valid, 1);
        check_val("drop_data", adc_data, 16'h3C96);
        act = 0;
        repeat (3000) begin
            @(negedge clk);
            if (adc_cnv || busy) act++;
        end
        check_val("drop_no_new_cnv", act, 0);

        // Overrun on the SAMPLE_PERIOD=100 instance
        en2 = 1'b1;
        repeat (150) @(negedge clk);
        check_val("ovr_busy_first", busy2, 1);
        check_val("ovr_miss_before", miss2, 0);
        repeat (100) @(negedge clk);
        check_val("ovr_miss_set", miss2, 1);
        en2 = 1'b0;
        repeat (300) @(negedge clk);
        check_val("ovr_idle", busy2, 0);
        check_val("ovr_miss_sticky", miss2, 1);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        check_val("ovr_miss_cleared", miss2, 0);
        // clear_err held high: a dropped tick must still set the flag
        clr2 = 1'b1;
        en2  = 1'b1;
        seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (miss2) seen = 1;
        end
        check_val("ovr_set_wins", seen, 1);
        clr2 = 1'b0;
        en2  = 1'b0;

        // Reset during SHIFT
        mdl_word = 16'h5A5A;
        enable   = 1'b1;
        n = 0;
        while (adc_cs_n && n < 1200) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check_val("pre_rst_in_shift", adc_cs_n, 0);
        #2 rstn = 1'b0;
        #1;
        check_val("async_cs_n", adc_cs_n, 1);
        check_val("async_sclk", adc_sclk, 0);
        check_val("async_busy", busy, 0);
        check_val("async_data", adc_data, 0);
        enable = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (adc_data_valid) act++;
        end
        rstn = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (adc_data_valid || busy) act++;
        end
        check_val("rst_abort_no_valid", act, 0);
        check_val("rst_abort_data", adc_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
